// File: rtl/approx_add_pkg.sv
// Shared definitions for the approx_add_pipe adder family: the mode
// encoding, the lower-part-OR (LOA) sum function and the saturating
// adder used by the error statistics counters.
package approx_add_pkg;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    // LOA sum on operands zero-extended to 32 bits. The low k bits are a
    // bitwise OR. Bit k-1 generates the carry into the exact upper part.
    // A k of 0 (or less) gives the exact sum. The result is 33 bits wide,
    // so the carry-out is never lost.
    function automatic logic [32:0] loa_sum(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          k);
        logic [32:0] lo_mask;
        logic [32:0] hi;
        logic [31:0] gen;
        logic        c;
        if (k <= 0) begin
            return {1'b0, a} + {1'b0, b};
        end
        lo_mask = (33'd1 << k) - 33'd1;
        gen     = (a & b) >> (k - 1);
        c       = gen[0];
        hi      = ({1'b0, a >> k} + {1'b0, b >> k} + {32'd0, c}) << k;
        return hi | (({1'b0, a} | {1'b0, b}) & lo_mask);
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational LOA/exact adder. In approximate mode the low APPROX_BITS
// bits are OR-ed. In exact mode the full sum is produced. The output
// always includes the carry-out.
module approx_add_core
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2
)(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mode,
    output logic [WIDTH:0]   o_sum
);

    // Exact mode is simply an LOA with no approximated bits.
    always_comb begin
        o_sum = (WIDTH+1)'(loa_sum(32'(i_a), 32'(i_b),
                                   (i_mode == MODE_EXACT) ? 0 : APPROX_BITS));
    end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder with a valid/ready stream interface.
// Stage 0 computes the sum. Later stages only carry the result and a
// valid bit. The whole pipeline advances unless the output is stalled.
// The optional error monitor is enabled by defining APPROX_ADD_ERR_MON_EN.
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2,
    parameter int STAGES      = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   O
`ifdef APPROX_ADD_ERR_MON_EN
   ,input  logic             clr_stats,
    output logic [31:0]      err_cnt,
    output logic [31:0]      err_sum,
    output logic [WIDTH:0]   err_max
`endif
);

    logic           w_advance;
    logic [WIDTH:0] w_sum;
    logic           r_vld [STAGES];
    logic [WIDTH:0] r_sum [STAGES];

    // A single global enable: everything moves unless the last stage is held.
    assign w_advance = !(out_valid && !out_ready);
    assign in_ready  = w_advance && !rst;
    assign out_valid = r_vld[STAGES-1];
    assign O         = r_sum[STAGES-1];

    approx_add_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .i_a    (A),
        .i_b    (B),
        .i_mode (mode),
        .o_sum  (w_sum)
    );

    // Pipeline shift register for the result and its valid bit.
    // NOTE: state uses non-blocking assignments so every stage samples the
    // previous stage's old value on the same edge; blocking here would
    // collapse the pipeline into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_sum[s] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            r_sum[0] <= w_sum;
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_sum[s] <= r_sum[s-1];
            end
        end
    end

`ifdef APPROX_ADD_ERR_MON_EN
    logic           w_exact;
    logic [WIDTH:0] w_exact_sum;
    logic [WIDTH:0] w_exact_out;
    logic [WIDTH:0] w_err;
    logic           w_out_xfer;
    logic [WIDTH:0] r_exact [STAGES];
    logic [31:0]    r_err_cnt;
    logic [31:0]    r_err_sum;
    logic [WIDTH:0] r_err_max;

    assign w_exact     = MODE_EXACT;
    assign w_exact_out = r_exact[STAGES-1];
    assign w_out_xfer  = out_valid && out_ready;
    assign err_cnt     = r_err_cnt;
    assign err_sum     = r_err_sum;
    assign err_max     = r_err_max;

    approx_add_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_exact_core (
        .i_a    (A),
        .i_b    (B),
        .i_mode (w_exact),
        .o_sum  (w_exact_sum)
    );

    // Exact reference sum travels alongside each pipeline entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) r_exact[s] <= '0;
        end else if (w_advance) begin
            r_exact[0] <= w_exact_sum;
            for (int s = 1; s < STAGES; s++) r_exact[s] <= r_exact[s-1];
        end
    end

    // Absolute error of the result that is leaving the pipeline.
    always_comb begin
        w_err = '0;
        if (w_exact_out >= O) w_err = w_exact_out - O;
        else                  w_err = O - w_exact_out;
    end

    // Statistics update on output transfers. A clear overrides the sample.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_err_cnt <= '0;
            r_err_sum <= '0;
            r_err_max <= '0;
        end else if (w_out_xfer) begin
            if (w_err != '0)      r_err_cnt <= sat_add32(r_err_cnt, 32'd1);
            r_err_sum <= sat_add32(r_err_sum, 32'(w_err));
            if (w_err > r_err_max) r_err_max <= w_err;
        end
    end
`endif

endmodule
